// File: rtl/gfx_pkg.sv
// Shared graphics types and constants for the pixel compositor.
// Palette index layout: {2'b00, pf} playfield, {2'b01, mo} motion object, {2'b10, 0} border.
package gfx_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned PAL_PF_BASE = 0;
  localparam int unsigned PAL_MO_BASE = 4;
  localparam int unsigned PAL_BORDER  = 8;

  localparam rgb_t BLANK_RGB = '0;

  // Motion-object entries mirror the playfield entries; border is dark grey.
  localparam rgb_t DEFAULT_PAL [16] = '{
    24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFFFC,
    24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFFFC,
    24'h0F0F0F, 24'h000000, 24'h000000, 24'h000000,
    24'h000000, 24'h000000, 24'h000000, 24'h000000
  };

  // Reset value of a palette entry; entries beyond the table are black.
  function automatic rgb_t default_pal(input int unsigned idx);
    if (idx < 16) begin
      return DEFAULT_PAL[idx[3:0]];
    end
    return BLANK_RGB;
  endfunction

endpackage

// File: rtl/pixel_delay_line.sv
// Fixed-depth shift register with a parameterised reset value.
module pixel_delay_line #(
  parameter int unsigned W       = 1,
  parameter int unsigned DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q [DEPTH];
  logic [W-1:0] data_d [DEPTH];

  // Shift one stage per clock.
  always_comb begin
    data_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i] = data_q[i-1];
    end
  end

  // Stage registers; every stage loads the reset value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// Per-pixel compositor: windowed playfield addressing, fixed-priority motion-object merge,
// palette lookup and pixel-aligned sync/blank. Latency is PF_LAT + 3 cycles.
// Optional feature macro: PIXEL_COMPOSITOR_PAL_WR_EN (writable palette; constant when undefined).
module pixel_compositor
  import gfx_pkg::*;
#(
  parameter int unsigned COL_W    = 10,
  parameter int unsigned ROW_W    = 9,
  parameter int unsigned CODE_W   = 2,
  parameter int unsigned NUM_MO   = 4,
  parameter int unsigned PF_LAT   = 1,
  parameter int unsigned FIELD_X0 = 192,
  parameter int unsigned FIELD_Y0 = 112,
  parameter int unsigned FIELD_W  = 256,
  parameter int unsigned FIELD_H  = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [COL_W-1:0]             in_col,
  input  logic [ROW_W-1:0]             in_row,
  input  logic                         in_blank_n,
  input  logic                         in_hs,
  input  logic                         in_vs,
  output logic [$clog2(FIELD_W/8)+$clog2(FIELD_H/8)-1:0] pf_addr,
  output logic [2:0]                   tile_row,
  output logic [2:0]                   tile_col,
  output logic [7:0]                   field_row,
  output logic [7:0]                   field_col,
  input  logic [CODE_W-1:0]            pf_code,
  input  logic [NUM_MO*CODE_W-1:0]     mo_code,
  input  logic                         pal_we,
  input  logic [CODE_W+1:0]            pal_addr,
  input  logic [23:0]                  pal_wdata,
  output logic [7:0]                   out_r,
  output logic [7:0]                   out_g,
  output logic [7:0]                   out_b,
  output logic                         out_hs,
  output logic                         out_vs,
  output logic                         out_blank_n
);

  localparam int unsigned TX_W  = $clog2(FIELD_W / 8);
  localparam int unsigned TY_W  = $clog2(FIELD_H / 8);
  localparam int unsigned LAT   = PF_LAT + 3;
  localparam int unsigned IDX_W = CODE_W + 2;
  localparam int unsigned NPAL  = 1 << IDX_W;

  // ---------------- Stage A: window mapping ----------------
  logic [COL_W:0]   dx;
  logic [ROW_W:0]   dy;
  logic [COL_W-1:0] fx_d, fx_q;
  logic [ROW_W-1:0] fy_d, fy_q;
  logic             in_field_d, in_field_q;
  logic             vis_a_d, vis_a_q;

  // Extra top bit carries the borrow so pixels left of/above the window fall outside.
  assign dx = {1'b0, in_col} - (COL_W + 1)'(FIELD_X0);
  assign dy = {1'b0, in_row} - (ROW_W + 1)'(FIELD_Y0);

  // Window-relative position and inside-window flag.
  always_comb begin
    fx_d       = dx[COL_W-1:0];
    fy_d       = dy[ROW_W-1:0];
    in_field_d = in_blank_n && !dx[COL_W] && !dy[ROW_W] &&
                 (32'(fx_d) < FIELD_W) && (32'(fy_d) < FIELD_H);
    vis_a_d    = in_blank_n;
  end

  // Stage A registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fx_q       <= '0;
      fy_q       <= '0;
      in_field_q <= 1'b0;
      vis_a_q    <= 1'b0;
    end else begin
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      in_field_q <= in_field_d;
      vis_a_q    <= vis_a_d;
    end
  end

  assign pf_addr   = {fy_q[TY_W+2:3], fx_q[TX_W+2:3]};
  assign tile_row  = fy_q[2:0];
  assign tile_col  = fx_q[2:0];
  assign field_row = fy_q[7:0];
  assign field_col = fx_q[7:0];

  logic unused_fxy;
  assign unused_fxy = ^{fx_q[COL_W-1:8], fy_q[ROW_W-1:8]};

  // Carry window/blank flags across the tile-fetch latency.
  logic field_b, vis_b;

  pixel_delay_line #(
    .W       (2),
    .DEPTH   (PF_LAT),
    .RST_VAL (2'b00)
  ) u_flag_dly (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   ({in_field_q, vis_a_q}),
    .q_o   ({field_b, vis_b})
  );

  // ---------------- Stage B: priority composite ----------------
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic              vis_c_q;
  logic              mo_hit;
  logic [CODE_W-1:0] mo_sel;

  // Lowest-index nonzero motion object wins, then playfield; border outside the window.
  always_comb begin
    mo_hit = 1'b0;
    mo_sel = '0;
    for (int i = 0; i < NUM_MO; i++) begin
      if (!mo_hit && (mo_code[i*CODE_W +: CODE_W] != '0)) begin
        mo_hit = 1'b1;
        mo_sel = mo_code[i*CODE_W +: CODE_W];
      end
    end
    if (!field_b) begin
      idx_d = {2'b10, {CODE_W{1'b0}}};
    end else if (mo_hit) begin
      idx_d = {2'b01, mo_sel};
    end else begin
      idx_d = {2'b00, pf_code};
    end
  end

  // Stage B registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      vis_c_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      vis_c_q <= vis_b;
    end
  end

  // ---------------- Palette ----------------
  rgb_t pal_rd;

`ifdef PIXEL_COMPOSITOR_PAL_WR_EN
  rgb_t pal_q [NPAL];
  rgb_t pal_d [NPAL];

  // Write port; the Stage C read in the same cycle still sees the old entry.
  always_comb begin
    pal_d = pal_q;
    if (pal_we) begin
      pal_d[pal_addr] = pal_wdata;
    end
  end

  // Palette storage, restored to defaults on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPAL; i++) begin
        pal_q[i] <= default_pal(i);
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  assign pal_rd = pal_q[idx_q];
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we, pal_addr, pal_wdata};
  assign pal_rd     = default_pal(32'(idx_q));
`endif

  // ---------------- Stage C: colour output ----------------
  rgb_t rgb_d, rgb_q;

  // Blanked pixels are forced to black.
  always_comb begin
    rgb_d = vis_c_q ? pal_rd : BLANK_RGB;
  end

  // Output colour register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= BLANK_RGB;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign out_r = rgb_q.r;
  assign out_g = rgb_q.g;
  assign out_b = rgb_q.b;

  // Sync and blank follow the full pipeline depth; syncs idle high.
  pixel_delay_line #(
    .W       (3),
    .DEPTH   (LAT),
    .RST_VAL (3'b110)
  ) u_sync_dly (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   ({in_hs, in_vs, in_blank_n}),
    .q_o   ({out_hs, out_vs, out_blank_n})
  );

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed self-checking bench for pixel_compositor with default parameters.
module tb_pixel_compositor;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  in_col;
  logic [8:0]  in_row;
  logic        in_blank_n, in_hs, in_vs;
  logic [9:0]  pf_addr;
  logic [2:0]  tile_row, tile_col;
  logic [7:0]  field_row, field_col;
  logic [1:0]  pf_code;
  logic [7:0]  mo_code;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic [7:0]  out_r, out_g, out_b;
  logic        out_hs, out_vs, out_blank_n;

  // Codes requested with a pixel reach the DUT two edges later, like a 1-cycle tile RAM.
  logic [1:0]  pf_val, pf_p1;
  logic [7:0]  mo_val, mo_p1;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef PIXEL_COMPOSITOR_PAL_WR_EN
  localparam logic [23:0] EXP_WR = 24'h123456;
`else
  localparam logic [23:0] EXP_WR = 24'hFF0000;
`endif

  pixel_compositor dut (
    .clk         (clk),
    .reset       (reset),
    .in_col      (in_col),
    .in_row      (in_row),
    .in_blank_n  (in_blank_n),
    .in_hs       (in_hs),
    .in_vs       (in_vs),
    .pf_addr     (pf_addr),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .field_row   (field_row),
    .field_col   (field_col),
    .pf_code     (pf_code),
    .mo_code     (mo_code),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_wdata   (pal_wdata),
    .out_r       (out_r),
    .out_g       (out_g),
    .out_b       (out_b),
    .out_hs      (out_hs),
    .out_vs      (out_vs),
    .out_blank_n (out_blank_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pf_p1   <= pf_val;
    pf_code <= pf_p1;
    mo_p1   <= mo_val;
    mo_code <= mo_p1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, out_r, out_g, out_b};
  endfunction

  task automatic drive(input logic [9:0] c, input logic [8:0] r, input logic bn,
                       input logic [1:0] pf, input logic [7:0] mo);
    @(negedge clk);
    in_col     = c;
    in_row     = r;
    in_blank_n = bn;
    pf_val     = pf;
    mo_val     = mo;
    pal_we     = 1'b0;
  endtask

  task automatic idle();
    drive(10'd0, 9'd0, 1'b0, 2'd0, 8'h00);
  endtask

  // One isolated pixel; colour checked 4 cycles later. wr writes entry 1 during its palette read.
  task automatic pixel(input string tag, input logic [9:0] c, input logic [8:0] r,
                       input logic bn, input logic [1:0] pf, input logic [7:0] mo,
                       input logic [23:0] exp, input bit wr);
    drive(c, r, bn, pf, mo);
    idle();
    idle();
    idle();
    if (wr) begin
      pal_we    = 1'b1;
      pal_addr  = 4'd1;
      pal_wdata = 24'h123456;
    end
    @(negedge clk);
    check(tag, rgb(), {8'h00, exp});
    pal_we = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    in_col     = '0;
    in_row     = '0;
    in_blank_n = 1'b0;
    in_hs      = 1'b1;
    in_vs      = 1'b1;
    pf_val     = '0;
    mo_val     = '0;
    pal_we     = 1'b0;
    pal_addr   = '0;
    pal_wdata  = '0;

    // Reset state
    repeat (10) @(negedge clk);
    check("rst_rgb", rgb(), 32'h0);
    check("rst_hs", {31'd0, out_hs}, 32'd1);
    check("rst_vs", {31'd0, out_vs}, 32'd1);
    check("rst_blank_n", {31'd0, out_blank_n}, 32'd0);
    check("rst_pf_addr", {22'd0, pf_addr}, 32'd0);
    reset = 1'b0;
    repeat (4) idle();

    // Playfield pixel, addressing and exact latency
    drive(10'd200, 9'd120, 1'b1, 2'd1, 8'h00);
    idle();
    check("pf_addr", {22'd0, pf_addr}, {22'd0, 5'd1, 5'd1});
    check("tile_row", {29'd0, tile_row}, 32'd0);
    check("tile_col", {29'd0, tile_col}, 32'd0);
    check("field_rc", {16'd0, field_row, field_col}, {16'd0, 8'd8, 8'd8});
    idle();
    idle();
    check("lat3_rgb", rgb(), 32'h0);
    check("lat3_blank_n", {31'd0, out_blank_n}, 32'd0);
    @(negedge clk);
    check("lat4_rgb", rgb(), 32'hFF0000);
    check("lat4_blank_n", {31'd0, out_blank_n}, 32'd1);
    idle();
    check("lat5_rgb", rgb(), 32'h0);

    // Priority
    pixel("prio_mo1", 10'd200, 9'd120, 1'b1, 2'd2, 8'h34, 24'hFF0000, 1'b0);
    pixel("prio_pf", 10'd200, 9'd120, 1'b1, 2'd2, 8'h00, 24'h00FF00, 1'b0);
    pixel("prio_mo0", 10'd200, 9'd120, 1'b1, 2'd1, 8'h03, 24'hFFFFFC, 1'b0);
    pixel("prio_mo3", 10'd200, 9'd120, 1'b1, 2'd1, 8'h80, 24'h00FF00, 1'b0);

    // Window edges and blank
    pixel("edge_col191", 10'd191, 9'd120, 1'b1, 2'd1, 8'h01, 24'h0F0F0F, 1'b0);
    pixel("edge_col192", 10'd192, 9'd120, 1'b1, 2'd1, 8'h00, 24'hFF0000, 1'b0);
    pixel("edge_col447", 10'd447, 9'd120, 1'b1, 2'd2, 8'h00, 24'h00FF00, 1'b0);
    pixel("edge_col448", 10'd448, 9'd120, 1'b1, 2'd1, 8'h00, 24'h0F0F0F, 1'b0);
    pixel("edge_row111", 10'd200, 9'd111, 1'b1, 2'd1, 8'h00, 24'h0F0F0F, 1'b0);
    pixel("edge_row367", 10'd200, 9'd367, 1'b1, 2'd2, 8'h00, 24'h00FF00, 1'b0);
    pixel("edge_row368", 10'd200, 9'd368, 1'b1, 2'd2, 8'h00, 24'h0F0F0F, 1'b0);
    pixel("blank_rgb", 10'd200, 9'd120, 1'b0, 2'd1, 8'h00, 24'h000000, 1'b0);

    // Palette write: same-cycle read returns old entry, next pixel sees the new one
    pixel("wr_same_cycle", 10'd200, 9'd120, 1'b1, 2'd1, 8'h00, 24'hFF0000, 1'b1);
    pixel("wr_next_pixel", 10'd200, 9'd120, 1'b1, 2'd1, 8'h00, EXP_WR, 1'b0);

    // Sync alignment
    idle();
    in_hs = 1'b0;
    in_vs = 1'b0;
    idle();
    in_hs = 1'b1;
    in_vs = 1'b1;
    idle();
    idle();
    check("sync_lat3", {30'd0, out_hs, out_vs}, 32'b11);
    @(negedge clk);
    check("sync_lat4", {30'd0, out_hs, out_vs}, 32'b00);
    @(negedge clk);
    check("sync_lat5", {30'd0, out_hs, out_vs}, 32'b11);

    // Mid-line reset on a steady stream of palette entry 1
    drive(10'd200, 9'd120, 1'b1, 2'd1, 8'h00);
    repeat (6) @(negedge clk);
    check("pre_reset_rgb", rgb(), {8'h00, EXP_WR});
    #2 reset = 1'b1;
    #1;
    check("mid_reset_rgb", rgb(), 32'h0);
    check("mid_reset_blank", {31'd0, out_blank_n}, 32'd0);
    check("mid_reset_hs", {31'd0, out_hs}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_reset_rgb", rgb(), 32'hFF0000);
    check("post_reset_blank", {31'd0, out_blank_n}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
